// File: rtl/apb_pkg.sv
// Shared definitions for the queued APB master: FSM encoding and command word layout.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Command word is packed as {write, addr, wdata, strb}.
  function automatic int unsigned cmd_width(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy, full and empty flags.
module apb_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_d;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    count_d = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge pclk) begin
    if (do_push) mem[wptr] <= din;
  end

  assign dout_c = mem[rptr];

endmodule

// File: rtl/apb_master_cmdq.sv
// APB4 master fed by a command FIFO, with one-hot slave decode, response channel and wait-state timeout.
module apb_master_cmdq
  import apb_pkg::*;
#(
  parameter int unsigned DATA     = 32,
  parameter int unsigned ADDR     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_SLV  = 4,
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR-1:0]         cmd_addr,
  input  logic [DATA-1:0]         cmd_wdata,
  input  logic [DATA/8-1:0]       cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA-1:0]         rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [NUM_SLV-1:0]      psel,
  output logic                    penable,
  output logic [ADDR-1:0]         paddr,
  output logic                    pwrite,
  output logic [DATA-1:0]         pwdata,
  output logic [DATA/8-1:0]       pstrb,
  input  logic [NUM_SLV-1:0]      pready,
  input  logic [NUM_SLV*DATA-1:0] prdata,
  input  logic [NUM_SLV-1:0]      pslverr
);

  localparam int unsigned STRB  = DATA / 8;
  localparam int unsigned CMD_W = cmd_width(ADDR, DATA);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned WT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  apb_state_e state_q, state_d;

  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [ADDR-1:0]    paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA-1:0]    pwdata_q, pwdata_d;
  logic [STRB-1:0]    pstrb_q, pstrb_d;
  logic [WT_W-1:0]    wait_q, wait_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic [CMD_W-1:0]   head_c;
  logic               head_write;
  logic [ADDR-1:0]    head_addr;
  logic [DATA-1:0]    head_wdata;
  logic [STRB-1:0]    head_strb;
  logic [SEL_BITS-1:0] head_idx;
  logic               dec_ok;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               launch;
  logic               xfer_done;
  logic               xfer_abort;

  logic               sel_ready;
  logic               sel_err;
  logic [DATA-1:0]    sel_rdata;

  assign push = cmd_valid && cmd_ready_q && !fifo_full;

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .pclk    (pclk),
    .presetn (presetn),
    .push    (push),
    .pop     (launch),
    .din     ({cmd_write, cmd_addr, cmd_wdata, cmd_strb}),
    .dout_c  (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign {head_write, head_addr, head_wdata, head_strb} = head_c;
  assign head_idx = head_addr[ADDR-1 -: SEL_BITS];
  assign dec_ok   = (32'(head_idx) < NUM_SLV);

  // Return-path mux steered by the registered one-hot select.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA +: DATA];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    wait_d        = wait_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    launch        = 1'b0;
    xfer_done     = 1'b0;
    xfer_abort    = 1'b0;

    case (state_q)
      ST_IDLE: launch = !fifo_empty;
      ST_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          xfer_done = 1'b1;
        end else if (TIMEOUT != 0 && wait_q == WT_W'(TIMEOUT - 1)) begin
          xfer_abort = 1'b1;
        end else begin
          wait_d = wait_q + WT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
          launch        = !fifo_empty;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (xfer_done || xfer_abort) begin
      psel_d        = '0;
      penable_d     = 1'b0;
      paddr_d       = '0;
      pwrite_d      = 1'b0;
      pwdata_d      = '0;
      pstrb_d       = '0;
      rsp_valid_d   = 1'b1;
      rsp_err_d     = xfer_abort || sel_err;
      rsp_timeout_d = xfer_abort;
      rsp_rdata_d   = (xfer_done && !pwrite_q && !sel_err) ? sel_rdata : '0;
      state_d       = ST_RESP;
    end

    // A decode miss skips the bus entirely and answers with an error.
    if (launch) begin
      if (dec_ok) begin
        state_d  = ST_SETUP;
        psel_d   = NUM_SLV'(1) << head_idx;
        paddr_d  = head_addr;
        pwrite_d = head_write;
        pwdata_d = head_write ? head_wdata : '0;
        pstrb_d  = head_write ? head_strb : '0;
      end else begin
        state_d       = ST_RESP;
        rsp_valid_d   = 1'b1;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
      end
    end

    cmd_ready_d = (fifo_count + CNT_W'(push) - CNT_W'(launch)) != CNT_W'(DEPTH);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      wait_q        <= wait_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb_master_cmdq.sv
// Scoreboard bench for apb_master_cmdq: address-driven slave models, APB and response monitors.
module tb_apb_master_cmdq;

  localparam int DATA = 32;
  localparam int ADDR = 32;
  localparam int NS   = 3;
  localparam int TO   = 8;

  typedef struct packed {
    logic [NS-1:0] sel;
    logic [31:0]   addr;
    logic          wr;
    logic [31:0]   wd;
    logic [3:0]    st;
  } xfer_t;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR-1:0]   cmd_addr = '0;
  logic [DATA-1:0]   cmd_wdata = '0;
  logic [3:0]        cmd_strb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [NS-1:0]     psel;
  logic              penable;
  logic [ADDR-1:0]   paddr;
  logic              pwrite;
  logic [DATA-1:0]   pwdata;
  logic [3:0]        pstrb;
  logic [NS-1:0]     pready = '0;
  logic [NS*DATA-1:0] prdata = '0;
  logic [NS-1:0]     pslverr = '0;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 1;

  xfer_t       apb_q[$];
  int          cyc_q[$];
  logic [33:0] rsp_q[$];

  apb_master_cmdq #(
    .DATA(DATA), .ADDR(ADDR), .DEPTH(4), .NUM_SLV(NS), .SEL_BITS(2), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave behaviour is a pure function of the address: wait=[7:5], stuck=[8], error=[9].
  function automatic logic [31:0] rd(input logic [31:0] a, input int i);
    logic [31:0] k;
    k = 32'h9E37_79B9 * 32'(i + 1);
    return {a[15:0], ~a[31:16]} ^ k;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=timeout exp=event", nm);
  endtask

  task automatic expect_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st);
    int    idx;
    int    w;
    xfer_t x;
    idx = int'(a[31:30]);
    w   = int'(a[7:5]);
    if (idx >= NS) begin
      rsp_q.push_back({32'h0, 1'b1, 1'b0});
    end else begin
      x.sel  = NS'(1 << idx);
      x.addr = a;
      x.wr   = wr;
      x.wd   = wr ? wd : 32'h0;
      x.st   = wr ? st : 4'h0;
      apb_q.push_back(x);
      cyc_q.push_back(a[8] ? TO : w + 1);
      if (a[8]) rsp_q.push_back({32'h0, 1'b1, 1'b1});
      else      rsp_q.push_back({(wr || a[9]) ? 32'h0 : rd(a, idx), a[9], 1'b0});
    end
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    @(negedge pclk);
    while (!cmd_ready && n < 500) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) fail_now("send_accept");
    else expect_cmd(wr, a, wd, st);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0 || rsp_valid || psel != '0) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 3000) fail_now("drain");
    @(posedge pclk);
    #1;
  endtask

  always @(posedge pclk) begin
    #1;
    rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Selected slave answers per address; unselected slaves drive noise.
  int acc_s[NS];
  always @(negedge pclk) begin
    for (int i = 0; i < NS; i++) begin
      if (psel[i] && penable) begin
        acc_s[i]++;
        pready[i]  = !paddr[8] && (acc_s[i] > int'(paddr[7:5]));
        pslverr[i] = paddr[9];
        prdata[i*DATA +: DATA] = rd(paddr, i);
      end else begin
        acc_s[i]   = 0;
        pready[i]  = 1'($urandom_range(0, 1));
        pslverr[i] = 1'($urandom_range(0, 1));
        prdata[i*DATA +: DATA] = $urandom;
      end
    end
  end

  // APB-side monitor.
  xfer_t cur;
  int    acc;
  int    exp_cyc;
  bit    in_x;
  always @(negedge pclk) begin
    if (!presetn) begin
      in_x = 1'b0;
      acc  = 0;
      apb_q.delete();
      cyc_q.delete();
    end else if (psel != '0 && !penable) begin
      if (apb_q.size() == 0) begin
        fail_now("unexpected_setup");
      end else begin
        cur     = apb_q.pop_front();
        exp_cyc = cyc_q.pop_front();
        chk("setup_fields", {psel, paddr, pwrite, pwdata, pstrb}, cur);
      end
      in_x = 1'b1;
      acc  = 0;
    end else if (psel != '0) begin
      acc++;
      chk("access_stable", {psel, paddr, pwrite, pwdata, pstrb}, cur);
    end else begin
      if (in_x) begin
        chk("access_cycles", acc, exp_cyc);
        in_x = 1'b0;
      end
      chk("idle_zero", {penable, paddr, pwrite, pwdata, pstrb}, '0);
    end
  end

  // Response-side monitor.
  logic [33:0] held;
  bit          hold;
  always @(negedge pclk) begin
    if (!presetn) begin
      hold = 1'b0;
      rsp_q.delete();
    end else begin
      if (hold) chk("rsp_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, held});
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail_now("unexpected_rsp");
        else chk("rsp", {rsp_rdata, rsp_err, rsp_timeout}, rsp_q.pop_front());
        hold = 1'b0;
      end else if (rsp_valid) begin
        hold = 1'b1;
        held = {rsp_rdata, rsp_err, rsp_timeout};
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    int last;
    int cyc;
    int hs;
    int n;
    logic [31:0] a;
    int r;

    repeat (3) @(posedge pclk);
    #1;
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable,
                          paddr, pwrite, pwdata, pstrb}, '0);
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    chk("cmd_ready_before_clk", cmd_ready, 0);
    @(posedge pclk);
    #1;
    chk("cmd_ready_after_clk", cmd_ready, 1);

    // Single write, zero wait states: observe phase timing.
    send(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    chk("psel_before_pop", psel, 0);
    @(posedge pclk); #1;
    chk("setup_phase", {psel, penable}, 4'b0010);
    @(posedge pclk); #1;
    chk("access_phase", {psel, penable}, 4'b0011);
    @(posedge pclk); #1;
    chk("write_rsp", {rsp_valid, rsp_err, psel}, 5'b10000);
    wait_idle();

    // Read from slave 1 with three wait states.
    send(1'b0, 32'h4000_0070, 32'h0, 4'h0);
    wait_idle();

    // Fill the FIFO while responses are stalled, then drain back to back.
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) send(1'b1, 32'(i) << 12, $urandom, 4'(i + 1));
    chk("cmd_ready_full", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_5000;
    repeat (3) begin
      @(negedge pclk);
      chk("no_push_when_full", cmd_ready, 0);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    rdy_mode = 1;
    last = -1; cyc = 0; hs = 0;
    while (hs < 5 && cyc < 100) begin
      @(negedge pclk);
      cyc++;
      if (rsp_valid && rsp_ready) begin
        if (last >= 0) chk("b2b_gap", cyc - last, 3);
        last = cyc;
        hs++;
      end
    end
    if (hs < 5) fail_now("b2b_drain");
    wait_idle();

    // Stuck slave 2 times out; the following command completes normally.
    send(1'b1, 32'h8000_0100, 32'h1111_2222, 4'h3);
    send(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    wait_idle();

    // Decode miss answers one cycle after the pop with no bus activity.
    send(1'b1, 32'hC000_0000, 32'h5555_AAAA, 4'hF);
    @(posedge pclk); #1;
    chk("decode_err_rsp", {rsp_valid, rsp_err, rsp_timeout, psel}, 6'b110000);
    wait_idle();
    send(1'b0, 32'h4000_0200, 32'h0, 4'h0);
    wait_idle();

    // Asynchronous reset during a stuck access with commands queued behind it.
    send(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    send(1'b1, 32'h0000_0000, 32'hCAFE_0001, 4'h1);
    send(1'b1, 32'h0000_1000, 32'hCAFE_0002, 4'h2);
    n = 0;
    while (!penable && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!penable) fail_now("reach_access");
    repeat (2) @(negedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    chk("async_reset_drop", {psel, penable, rsp_valid, cmd_ready}, '0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    chk("cmd_ready_release", cmd_ready, 0);
    @(posedge pclk); #1;
    chk("cmd_ready_return", cmd_ready, 1);
    repeat (3) begin
      @(posedge pclk); #1;
      chk("fifo_flushed", {psel, rsp_valid}, '0);
    end
    send(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hC);
    wait_idle();

    // Randomised traffic with random response back-pressure.
    rdy_mode = 2;
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge pclk); #1;
      end
      a = $urandom;
      r = $urandom_range(0, 9);
      a[31:30] = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a[8] = ($urandom_range(0, 7) == 0);
      a[9] = ($urandom_range(0, 5) == 0);
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
